// File: rtl/collision_scheduler.sv
// Shares one combinational collision unit between two player sweeps and CPU queries.
// Sweeps run on frame ticks; CPU queries are served between sweeps.
module collision_scheduler #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [31:0] pos1,
    input  logic [31:0] pos2,
    input  logic [3:0]  coll_in,
    output logic [31:0] player_pos,
    output logic [31:0] collis1,
    output logic [31:0] collis2,
    output logic        sweep_done,
    input  logic        cpu_req,
    input  logic [31:0] cpu_pos,
    output logic        cpu_ack,
    output logic [31:0] cpu_coll,
    output logic        overrun,
    input  logic        overrun_clr
);

    typedef enum logic [2:0] {
        IDLE,
        DRV_P1,
        DRV_P2,
        DONE,
        CPU_DRV
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [31:0] s1_q, s1_d;
    logic [31:0] s2_q, s2_d;
    logic [31:0] pos_q, pos_d;
    logic [3:0]  c1_q, c1_d;
    logic [3:0]  c2_q, c2_d;
    logic [3:0]  cc_q, cc_d;
    logic        ack_q, ack_d;
    logic        settled;
    logic        busy_tick;

    assign settled   = (cnt_q == LAST);
    assign busy_tick = frame_tick && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        pos_d   = pos_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        cc_d    = cc_q;
        ack_d   = 1'b0;

        if (busy_tick) begin
            pend_d = 1'b1;
        end

        // A lost tick must stay visible even if software clears in the same cycle
        if (busy_tick && pend_q) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        unique case (state_q)
            IDLE: begin
                if (frame_tick || pend_q) begin
                    s1_d    = pos1;
                    s2_d    = pos2;
                    pend_d  = 1'b0;
                    pos_d   = pos1;
                    cnt_d   = 4'd0;
                    state_d = DRV_P1;
                end else if (cpu_req) begin
                    pos_d   = cpu_pos;
                    cnt_d   = 4'd0;
                    state_d = CPU_DRV;
                end
            end
            DRV_P1: begin
                pos_d = s1_q;
                if (settled) begin
                    c1_d    = coll_in;
                    pos_d   = s2_q;
                    cnt_d   = 4'd0;
                    state_d = DRV_P2;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DRV_P2: begin
                if (settled) begin
                    c2_d    = coll_in;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            CPU_DRV: begin
                if (settled) begin
                    cc_d    = coll_in;
                    ack_d   = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            s1_q    <= 32'd0;
            s2_q    <= 32'd0;
            pos_q   <= 32'd0;
            c1_q    <= 4'd0;
            c2_q    <= 4'd0;
            cc_q    <= 4'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pos_q   <= pos_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            cc_q    <= cc_d;
            ack_q   <= ack_d;
        end
    end

    assign player_pos = pos_q;
    assign collis1    = {28'd0, c1_q};
    assign collis2    = {28'd0, c2_q};
    assign cpu_coll   = {28'd0, cc_q};
    assign cpu_ack    = ack_q;
    assign overrun    = ovr_q;
    assign sweep_done = (state_q == DONE);

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler with a behavioural collision unit.
// Stimulus pushes expected sweep/query results; a monitor checks them on output.
module tb_collision_scheduler;

    localparam int SETTLE = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic [31:0] pos1 = '0;
    logic [31:0] pos2 = '0;
    logic [3:0]  coll_in;
    logic [31:0] player_pos;
    logic [31:0] collis1;
    logic [31:0] collis2;
    logic        sweep_done;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_pos = '0;
    logic        cpu_ack;
    logic [31:0] cpu_coll;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int checks = 0;
    int fails  = 0;

    logic [7:0] sweep_q[$];
    logic [3:0] cpu_q[$];
    logic [7:0] se;
    logic [3:0] ce;

    collision_scheduler #(.SETTLE(SETTLE)) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .pos1       (pos1),
        .pos2       (pos2),
        .coll_in    (coll_in),
        .player_pos (player_pos),
        .collis1    (collis1),
        .collis2    (collis2),
        .sweep_done (sweep_done),
        .cpu_req    (cpu_req),
        .cpu_pos    (cpu_pos),
        .cpu_ack    (cpu_ack),
        .cpu_coll   (cpu_coll),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] coll_f(input logic [31:0] p);
        case (p)
            32'h00600168: coll_f = 4'h2;
            32'h01000168: coll_f = 4'h8;
            32'h00430014: coll_f = 4'h4;
            default:      coll_f = p[3:0] ^ p[23:20];
        endcase
    endfunction

    assign coll_in = coll_f(player_pos);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_player_pos"}, player_pos, 32'h0);
        chk({tag, "_collis1"}, collis1, 32'h0);
        chk({tag, "_collis2"}, collis2, 32'h0);
        chk({tag, "_cpu_coll"}, cpu_coll, 32'h0);
        chk({tag, "_sweep_done"}, 32'(sweep_done), 32'h0);
        chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'h0);
        chk({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (sweep_done) begin
                if (sweep_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sweep_unexpected: got sweep_done=1 expected none");
                end else begin
                    se = sweep_q.pop_front();
                    chk("sb_collis1", collis1, {28'h0, se[7:4]});
                    chk("sb_collis2", collis2, {28'h0, se[3:0]});
                end
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL ack_unexpected: got cpu_ack=1 expected none");
                end else begin
                    ce = cpu_q.pop_front();
                    chk("sb_cpu_coll", cpu_coll, {28'h0, ce});
                end
            end
            if (sweep_done || cpu_ack) begin
                chk("done_ack_exclusive", 32'(sweep_done & cpu_ack), 32'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int done_at;
        int ack_at;
        int n;

        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;
        step();

        // Basic sweep with snapshot hold
        pos1 = 32'h00600168;
        pos2 = 32'h01000168;
        sweep_q.push_back(8'h28);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("c1_player_pos", player_pos, 32'h00600168);
        chk("c1_sweep_done", 32'(sweep_done), 32'h0);
        pos1 = 32'h00700168;
        step();
        chk("c2_snapshot_hold", player_pos, 32'h00600168);
        chk("c2_collis1_old", collis1, 32'h0);
        step();
        chk("c3_player_pos", player_pos, 32'h01000168);
        chk("c3_collis1", collis1, 32'h2);
        step();
        chk("c4_player_pos", player_pos, 32'h01000168);
        chk("c4_collis2_old", collis2, 32'h0);
        step();
        chk("c5_sweep_done", 32'(sweep_done), 32'h1);
        chk("c5_collis2", collis2, 32'h8);
        step();
        chk("c6_sweep_done", 32'(sweep_done), 32'h0);
        pos1 = 32'h00600168;

        // Isolated CPU query
        cpu_pos = 32'h00430014;
        cpu_req = 1'b1;
        cpu_q.push_back(4'h4);
        step();
        chk("q_player_pos", player_pos, 32'h00430014);
        chk("q_ack_early1", 32'(cpu_ack), 32'h0);
        step();
        chk("q_ack_early2", 32'(cpu_ack), 32'h0);
        step();
        chk("q_ack", 32'(cpu_ack), 32'h1);
        chk("q_cpu_coll", cpu_coll, 32'h4);
        chk("q_collis1_kept", collis1, 32'h2);
        chk("q_collis2_kept", collis2, 32'h8);
        cpu_req = 1'b0;
        step();
        chk("q_ack_pulse", 32'(cpu_ack), 32'h0);
        chk("q_cpu_coll_hold", cpu_coll, 32'h4);

        // Tick and request together: sweep first
        cpu_pos = 32'h00000035;
        sweep_q.push_back(8'h28);
        cpu_q.push_back(4'h5);
        frame_tick = 1'b1;
        cpu_req = 1'b1;
        step();
        frame_tick = 1'b0;
        done_at = -1;
        ack_at = -1;
        for (int i = 1; i <= 30; i++) begin
            if (sweep_done) done_at = i;
            if (cpu_ack) begin
                ack_at = i;
                cpu_req = 1'b0;
                break;
            end
            step();
        end
        chk("prio_done_cycle", 32'(done_at), 32'(2 * SETTLE + 1));
        chk("prio_ack_seen", 32'(ack_at > 0), 32'h1);
        chk("prio_ack_after_done", 32'(ack_at > done_at), 32'h1);
        step();

        // Two ticks during a query
        cpu_pos = 32'h00430014;
        cpu_req = 1'b1;
        cpu_q.push_back(4'h4);
        step();
        frame_tick = 1'b1;
        step();
        chk("ovr_not_yet", 32'(overrun), 32'h0);
        step();
        frame_tick = 1'b0;
        cpu_req = 1'b0;
        chk("ovr_ack", 32'(cpu_ack), 32'h1);
        chk("ovr_set", 32'(overrun), 32'h1);
        sweep_q.push_back(8'h28);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (sweep_done) n++;
            step();
        end
        chk("ovr_one_sweep", 32'(n), 32'h1);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // Reset in DRV_P2
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        chk("rst_in_p2", player_pos, 32'h01000168);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        step();
        step();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (sweep_done) n++;
            step();
        end
        chk("rst_no_done", 32'(n), 32'h0);

        pos1 = 32'h00000013;
        pos2 = 32'h00900006;
        sweep_q.push_back(8'h3F);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            if (sweep_done) begin
                done_at = i;
                break;
            end
            step();
        end
        chk("post_rst_done_cycle", 32'(done_at), 32'(2 * SETTLE + 1));
        chk("post_rst_collis1", collis1, 32'h3);
        chk("post_rst_collis2", collis2, 32'hF);
        step();
        step();

        chk("sweep_queue_empty", 32'(sweep_q.size()), 32'h0);
        chk("cpu_queue_empty", 32'(cpu_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
